// File: rtl/dmem_pkg.sv
// Shared types and widths for the L1 data-memory responder.
package dmem_pkg;

    localparam int DMEM_ADDR_W = 10;
    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_IDX_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } dmem_state_t;

    // A simultaneous read+write is carried as its own kind so the response can forward the write data.
    typedef enum logic [1:0] {
        OP_RD,
        OP_WR,
        OP_RDWR
    } dmem_op_t;

endpackage

// File: rtl/dmem_array.sv
// Backing store: synchronous write, registered read. Contents are never reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [DMEM_IDX_W-1:0]  waddr,
    input  logic [DMEM_DATA_W-1:0] wdata,
    input  logic                   re,
    input  logic [DMEM_IDX_W-1:0]  raddr,
    output logic [DMEM_DATA_W-1:0] rdata
);

    logic [DMEM_DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// L1 miss/write-through data-memory responder with programmable latency and a one-cycle ack.
// Optional build macro DMEM_PERF_CNT_EN adds saturating rd_count / wr_count outputs.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH      = 256,
    parameter int RD_LATENCY = 2,
    parameter int WR_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   dmem_rd_en,
    input  logic                   dmem_wr_en,
    input  logic [DMEM_ADDR_W-1:0] dmem_address,
    input  logic [DMEM_DATA_W-1:0] data_to_dmem,
    output logic [DMEM_DATA_W-1:0] data_from_dmem,
    output logic                   dmem_ack,
    output logic                   dmem_busy
`ifdef DMEM_PERF_CNT_EN
    ,
    output logic [15:0]            rd_count,
    output logic [15:0]            wr_count
`endif
);

    localparam logic [3:0] RD_CNT_INIT = 4'(RD_LATENCY - 1);
    localparam logic [3:0] WR_CNT_INIT = 4'(WR_LATENCY - 1);

    dmem_state_t            state;
    dmem_op_t               op_q;
    logic [3:0]             cnt;
    logic [DMEM_IDX_W-1:0]  idx_q;
    logic [DMEM_DATA_W-1:0] wdata_q;
    logic [DMEM_DATA_W-1:0] fwd_data_q;
    logic                   fwd_q;
    logic [DMEM_DATA_W-1:0] rdata;
    logic                   fire;
    logic                   accept;
    logic                   unused_addr_bits;

    assign unused_addr_bits = ^dmem_address[1:0];
    assign accept           = (state == IDLE) && (dmem_rd_en || dmem_wr_en);
    // The array is touched only on the ACCESS exit edge, so a reset beforehand drops the write.
    assign fire             = (state == ACCESS) && (cnt == 4'd0);

    dmem_array #(.DEPTH(DEPTH)) u_array (
        .clk   (clk),
        .we    (fire && (op_q != OP_RD)),
        .waddr (idx_q),
        .wdata (wdata_q),
        .re    (fire && (op_q == OP_RD)),
        .raddr (idx_q),
        .rdata (rdata)
    );

    // fwd_q selects the forwarded write word (also the reset-time zero) over the array read register.
    assign data_from_dmem = fwd_q ? fwd_data_q : rdata;

    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q   <= dmem_address[9:2];
            wdata_q <= data_to_dmem;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            op_q       <= OP_RD;
            cnt        <= 4'd0;
            dmem_ack   <= 1'b0;
            dmem_busy  <= 1'b0;
            fwd_q      <= 1'b1;
            fwd_data_q <= '0;
        end else begin
            dmem_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (dmem_wr_en) begin
                            op_q <= dmem_rd_en ? OP_RDWR : OP_WR;
                            cnt  <= WR_CNT_INIT;
                        end else begin
                            op_q <= OP_RD;
                            cnt  <= RD_CNT_INIT;
                        end
                        state     <= ACCESS;
                        dmem_busy <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        state    <= RESP;
                        dmem_ack <= 1'b1;
                        if (op_q == OP_RDWR) begin
                            fwd_q      <= 1'b1;
                            fwd_data_q <= wdata_q;
                        end else if (op_q == OP_RD) begin
                            fwd_q <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    dmem_busy <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    dmem_busy <= 1'b0;
                end
            endcase
        end
    end

`ifdef DMEM_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_count <= 16'd0;
            wr_count <= 16'd0;
        end else if (state == RESP) begin
            if (op_q == OP_RD) begin
                if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
            end else begin
                if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
            end
        end
    end
`endif

endmodule
